// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
// The state encoding and the select values are used by both the RTL and the bench.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    function automatic state_e grant_state(input logic owner);
        return (owner == SEL_B) ? GNT_B : GNT_A;
    endfunction

endpackage

// File: rtl/mux2_datapath.sv
// 2:1 data multiplexer steered by the arbiter's registered select.
module mux2_datapath #(
    parameter int DATA_W = 8
) (
    input  logic              sel_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts and a registered mux select.
//   state | meaning
//   IDLE  | no grant; nothing offered downstream
//   GNT_A | requester A owns the output
//   GNT_B | requester B owns the output
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sel
);

    state_e     state_q, state_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       sel_q, sel_d;
    logic       last_grant_q, last_grant_d;

    logic       own_valid;
    logic       oth_valid;
    state_e     oth_state;
    logic [3:0] beat_cnt_inc;

    assign own_valid    = (state_q == GNT_B) ? b_valid : a_valid;
    assign oth_valid    = (state_q == GNT_B) ? a_valid : b_valid;
    assign oth_state    = (state_q == GNT_B) ? GNT_A : GNT_B;
    assign beat_cnt_inc = beat_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= 4'd0;
            sel_q        <= SEL_A;
            last_grant_q <= SEL_B;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        out_valid    = 1'b0;
        a_ready      = 1'b0;
        b_ready      = 1'b0;

        if (state_q == IDLE) begin
            // On a tie the requester that did not own the last grant wins.
            if (a_valid && (!b_valid || last_grant_q == SEL_B)) begin
                state_d = GNT_A;
            end else if (b_valid) begin
                state_d = GNT_B;
            end
        end else begin
            out_valid = own_valid;
            a_ready   = (state_q == GNT_A) && out_ready;
            b_ready   = (state_q == GNT_B) && out_ready;
            if (!own_valid) begin
                state_d = oth_valid ? oth_state : IDLE;
            end else if (out_ready) begin
                if (beat_cnt_inc == 4'(BURST_MAX)) begin
                    if (oth_valid) begin
                        state_d = oth_state;
                    end else begin
                        beat_cnt_d = 4'd0;
                    end
                end else begin
                    beat_cnt_d = beat_cnt_inc;
                end
            end
        end

        // Any transition restarts the burst; sel and last_grant follow a new owner only.
        if (state_d != state_q) begin
            beat_cnt_d = 4'd0;
            if (state_d != IDLE) begin
                sel_d        = (state_d == GNT_B) ? SEL_B : SEL_A;
                last_grant_d = sel_d;
            end
        end
    end

    assign sel = sel_q;

    mux2_datapath #(
        .DATA_W(DATA_W)
    ) u_datapath (
        .sel_i(sel_q),
        .a_i  (a_data),
        .b_i  (b_data),
        .y_o  (out_data)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: reset, tie alternation, wrap, backpressure,
// early release and mid-burst reset, with hand-computed expectations.
module tb_mux2_rr_arbiter;
    import mux2_arb_pkg::*;

    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, b_valid;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ready, b_ready;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    logic              sel;

    int n_cmp = 0;
    int n_err = 0;

    mux2_rr_arbiter #(
        .DATA_W   (DATA_W),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("ready_onehot", 32'(a_ready & b_ready), 32'd0);
    endtask

    task automatic chk_grant(input string tag, input logic owner_b, input logic [DATA_W-1:0] exp_data);
        chk({tag, "_sel"},     32'(sel),      32'(owner_b));
        chk({tag, "_a_ready"}, 32'(a_ready),  32'(!owner_b && out_ready));
        chk({tag, "_b_ready"}, 32'(b_ready),  32'(owner_b && out_ready));
        chk({tag, "_data"},    32'(out_data), 32'(exp_data));
    endtask

    initial begin
        // Reset held two edges with both requesters valid.
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        a_data = 8'h11; b_data = 8'h22;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a_ready",   32'(a_ready),   32'd0);
        chk("rst_b_ready",   32'(b_ready),   32'd0);
        chk("rst_sel",       32'(sel),       32'd0);
        chk("rst_state",     32'(dut.state_q), 32'(IDLE));
        chk("rst_cnt",       32'(dut.beat_cnt_q), 32'd0);

        // Tie: 4 beats of A, 4 of B, alternating with no bubble.
        rst = 1'b0;
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            logic owner_b;
            owner_b = ((i / 4) % 2) == 1;
            chk_grant($sformatf("tie%0d", i), owner_b, owner_b ? 8'h22 : 8'h11);
            chk($sformatf("tie%0d_valid", i), 32'(out_valid), 32'd1);
            tick();
        end

        // Only A: ten beats, counter wraps at BURST_MAX, grant kept.
        b_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_data = 8'(8'h40 + i);
            #1;
            chk_grant($sformatf("solo%0d", i), 1'b0, 8'(8'h40 + i));
            chk($sformatf("solo%0d_cnt", i), 32'(dut.beat_cnt_q), 32'(i % 4));
            tick();
        end
        a_valid = 1'b0; a_data = 8'h11;
        tick();
        chk("solo_idle_state", 32'(dut.state_q), 32'(IDLE));
        chk("solo_idle_valid", 32'(out_valid), 32'd0);
        chk("solo_idle_sel",   32'(sel), 32'd0);

        // Backpressure on B with A waiting.
        b_valid = 1'b1;
        tick();
        chk_grant("bp_enter", 1'b1, 8'h22);
        tick();
        a_valid = 1'b1; out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk_grant($sformatf("bp_hold%0d", i), 1'b1, 8'h22);
            chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_cnt", i), 32'(dut.beat_cnt_q), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        for (int k = 1; k <= 3; k++) begin
            chk_grant($sformatf("bp_rest%0d", k), 1'b1, 8'h22);
            chk($sformatf("bp_rest%0d_cnt", k), 32'(dut.beat_cnt_q), 32'(k));
            tick();
        end
        chk_grant("bp_to_a", 1'b0, 8'h11);
        chk("bp_to_a_cnt", 32'(dut.beat_cnt_q), 32'd0);

        // Early release: A drops after two beats, B takes over directly.
        tick();
        tick();
        chk("er_cnt2", 32'(dut.beat_cnt_q), 32'd2);
        a_valid = 1'b0;
        #1;
        chk("er_out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("er_state", 32'(dut.state_q), 32'(GNT_B));
        chk("er_cnt0",  32'(dut.beat_cnt_q), 32'd0);
        chk_grant("er_b", 1'b1, 8'h22);

        // Reset during B's second beat, then A wins the first tie.
        a_valid = 1'b1;
        tick();
        chk("mr_cnt1", 32'(dut.beat_cnt_q), 32'd1);
        rst = 1'b1;
        tick();
        chk("mr_state",     32'(dut.state_q), 32'(IDLE));
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_a_ready",   32'(a_ready), 32'd0);
        chk("mr_b_ready",   32'(b_ready), 32'd0);
        chk("mr_sel",       32'(sel), 32'd0);
        rst = 1'b0;
        #1;
        tick();
        chk("mr_state_a", 32'(dut.state_q), 32'(GNT_A));
        chk_grant("mr_a", 1'b0, 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data width of both requesters and the output.
REQ-002 Parameter BURST_MAX, default 4, range 1..15, SHALL set the maximum beats per grant while the other requester waits.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-005 Ports a_valid, input, 1, and a_data, input, DATA_W, SHALL be requester A's offer.
REQ-006 Port a_ready, output, 1, SHALL indicate A's beat is accepted this cycle.
REQ-007 Ports b_valid, input, 1, and b_data, input, DATA_W, SHALL be requester B's offer.
REQ-008 Port b_ready, output, 1, SHALL indicate B's beat is accepted this cycle.
REQ-009 Ports out_valid, output, 1, and out_data, output, DATA_W, SHALL be the shared output offer.
REQ-010 Port out_ready, input, 1, SHALL be downstream acceptance.
REQ-011 Port sel, output, 1, SHALL be the registered mux select: 0 = A, 1 = B.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GNT_A, GNT_B.
REQ-013 In IDLE: out_valid=0, a_ready=0, b_ready=0.
- Next state GNT_A if only a_valid; GNT_B if only b_valid.
- If both are valid, the next state SHALL grant the requester opposite last_grant.
REQ-014 In GNT_X: out_data SHALL equal X_data through the 2:1 mux driven by sel, out_valid=X_valid, X_ready=out_ready, and the other ready=0.
REQ-015 A beat SHALL be a cycle with X_valid & out_ready; beat_cnt (4 bits) SHALL increment on each beat.
REQ-016 If X_valid=0 in GNT_X, the next state SHALL be GNT_other if other_valid, else IDLE.
REQ-017 On the beat that makes beat_cnt equal BURST_MAX:
- Next state GNT_other if other_valid.
- Otherwise stay in GNT_X with beat_cnt cleared.
REQ-018 On every grant change, beat_cnt SHALL clear to 0 and last_grant SHALL update to the new owner.
REQ-019 Grant latency SHALL be one cycle from IDLE; a direct GNT_A<->GNT_B switch SHALL insert no idle cycle.
REQ-020 With out_ready=0, the grant SHALL hold indefinitely while X_valid=1, and beat_cnt SHALL not change.
REQ-021 sel SHALL be registered and change only on a state transition: 0 for GNT_A, 1 for GNT_B, unchanged on entry to IDLE.
REQ-022 a_ready and b_ready SHALL never both be 1 in the same cycle.

Reset
REQ-023 While rst=1 at a clk edge:
- state=IDLE, beat_cnt=0, sel=0, last_grant=B (A wins the first tie).
- out_valid=0, a_ready=0, b_ready=0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst and discard no-longer-accepted beats; the first grant after reset SHALL follow REQ-013.

Structure
REQ-025 Package mux2_arb_pkg SHALL hold the state typedef (IDLE, GNT_A, GNT_B) and the constants SEL_A=0 and SEL_B=1.
REQ-026 The data path SHALL be one sub-module, mux2_datapath (DATA_W wide, out = sel ? b : a), instantiated once.
REQ-027 The FSM, beat counter and ready/valid steering SHALL live in mux2_rr_arbiter.

Verification
REQ-028 Reset: hold rst=1 for 2 cycles with a_valid=b_valid=1 -> out_valid=0, a_ready=b_ready=0, sel=0; first grant after release is A.
REQ-029 Tie, BURST_MAX=4, out_ready=1, a_data=0x11, b_data=0x22 -> out_data shows 4 beats of 0x11, then 4 of 0x22, alternating with no bubble.
REQ-030 Single requester: only a_valid=1 for 10 cycles -> 10 beats of A, sel stays 0, beat_cnt wraps at 4 without losing grant.
REQ-031 Backpressure: GNT_B with out_ready=0 for 5 cycles and a_valid=1 -> grant held on B, b_ready=0, beat_cnt unchanged; after out_ready=1, B finishes its remaining beats.
REQ-032 Early release: GNT_A, a_valid drops after 2 beats while b_valid=1 -> next cycle GNT_B, sel=1, beat_cnt=0.
REQ-033 Mid-burst reset: rst=1 for 1 cycle during GNT_B beat 2 -> IDLE next cycle; with both valid, A is granted one cycle later.
